// File: rtl/bmc_pipe.sv
// Branch-metric pipeline: computes the distance of each received symbol to
// every 1/N_OUT codeword, with depuncturing and a hard/soft mode per symbol.
module bmc_pipe #(
  parameter int unsigned N_OUT  = 2,
  parameter int unsigned SOFT_W = 3,
  parameter int unsigned IDX_W  = 16,
  localparam int unsigned BM_W  = $clog2(N_OUT * ((1 << SOFT_W) - 1) + 1),
  localparam int unsigned N_CW  = 1 << N_OUT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_OUT*SOFT_W-1:0]  rx_i,
  input  logic [N_OUT-1:0]         erase_i,
  input  logic                     hard_i,
  input  logic                     last_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_CW*BM_W-1:0]     bm_o,
  output logic                     last_o,
  output logic [IDX_W-1:0]         idx_o
);

  localparam int unsigned MAX_S = (1 << SOFT_W) - 1;
  localparam int unsigned DW    = N_OUT * SOFT_W;

  // S1: per-element distances against expected 0 (d0) and expected 1 (d1)
  logic              s1_v_q;
  logic [DW-1:0]     s1_d0_q, s1_d1_q;
  logic [DW-1:0]     d0_d, d1_d;
  logic              s1_last_q;
  logic [IDX_W-1:0]  s1_idx_q;

  // S2: summed metrics and side information
  logic                  s2_v_q;
  logic [N_CW*BM_W-1:0]  bm_d, bm_q;
  logic                  last_q;
  logic [IDX_W-1:0]      idx_q;

  logic [IDX_W-1:0]  cnt_q;
  logic              s2_load, s1_load, accept;

  // A stage may load when it is empty or its content leaves this cycle
  assign s2_load  = !s2_v_q || out_ready;
  assign s1_load  = !s1_v_q || s2_load;
  assign in_ready = rst_n && s1_load;
  assign accept   = in_valid && in_ready;

  // Per-element distances for both polarities; erased elements cost nothing
  always_comb begin
    d0_d = '0;
    d1_d = '0;
    for (int j = 0; j < N_OUT; j++) begin
      if (!erase_i[j]) begin
        if (hard_i) begin
          d0_d[j*SOFT_W +: SOFT_W] = SOFT_W'(rx_i[j*SOFT_W + SOFT_W - 1]);
          d1_d[j*SOFT_W +: SOFT_W] = SOFT_W'(!rx_i[j*SOFT_W + SOFT_W - 1]);
        end else begin
          d0_d[j*SOFT_W +: SOFT_W] = rx_i[j*SOFT_W +: SOFT_W];
          d1_d[j*SOFT_W +: SOFT_W] = SOFT_W'(MAX_S) - rx_i[j*SOFT_W +: SOFT_W];
        end
      end
    end
  end

  // Codeword metric: bit j of c selects which polarity of element j to add
  always_comb begin
    bm_d = '0;
    for (int c = 0; c < N_CW; c++) begin
      for (int j = 0; j < N_OUT; j++) begin
        if (((c >> j) & 1) != 0) begin
          bm_d[c*BM_W +: BM_W] = bm_d[c*BM_W +: BM_W] + BM_W'(s1_d1_q[j*SOFT_W +: SOFT_W]);
        end else begin
          bm_d[c*BM_W +: BM_W] = bm_d[c*BM_W +: BM_W] + BM_W'(s1_d0_q[j*SOFT_W +: SOFT_W]);
        end
      end
    end
  end

  // Pipeline registers and frame index counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_d0_q   <= '0;
      s1_d1_q   <= '0;
      s1_last_q <= 1'b0;
      s1_idx_q  <= '0;
      s2_v_q    <= 1'b0;
      bm_q      <= '0;
      last_q    <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        cnt_q <= last_i ? '0 : cnt_q + IDX_W'(1);
      end
      if (s1_load) begin
        s1_v_q <= in_valid;
        if (in_valid) begin
          s1_d0_q   <= d0_d;
          s1_d1_q   <= d1_d;
          s1_last_q <= last_i;
          s1_idx_q  <= cnt_q;
        end
      end
      if (s2_load) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          bm_q   <= bm_d;
          last_q <= s1_last_q;
          idx_q  <= s1_idx_q;
        end
      end
    end
  end

  assign out_valid = s2_v_q;
  assign bm_o      = bm_q;
  assign last_o    = last_q;
  assign idx_o     = idx_q;

endmodule

// File: tb/tb_bmc_pipe.sv
// Randomised and directed bench for bmc_pipe with a scoreboard model.
module tb_bmc_pipe;

  localparam int unsigned N_OUT  = 2;
  localparam int unsigned SOFT_W = 3;
  localparam int unsigned BM_W   = 4;
  localparam int unsigned N_CW   = 4;
  localparam int          MAX_S  = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready2;
  logic [5:0]  rx_i = '0;
  logic [1:0]  erase_i = '0;
  logic        hard_i = 1'b0;
  logic        last_i = 1'b0;
  logic        out_valid, out_valid2;
  logic        out_ready = 1'b0;
  logic [15:0] bm_o, bm2;
  logic        last_o, last2;
  logic [15:0] idx_o;
  logic [1:0]  idx2;

  bmc_pipe #(.N_OUT(N_OUT), .SOFT_W(SOFT_W), .IDX_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rx_i(rx_i), .erase_i(erase_i), .hard_i(hard_i), .last_i(last_i),
    .out_valid(out_valid), .out_ready(out_ready), .bm_o(bm_o),
    .last_o(last_o), .idx_o(idx_o)
  );

  bmc_pipe #(.N_OUT(N_OUT), .SOFT_W(SOFT_W), .IDX_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .rx_i(rx_i), .erase_i(erase_i), .hard_i(hard_i), .last_i(last_i),
    .out_valid(out_valid2), .out_ready(out_ready), .bm_o(bm2),
    .last_o(last2), .idx_o(idx2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bm;
    logic        last;
    int          idx;
  } exp_t;

  exp_t q[$];
  int   seen_idx[$];
  int   seen_last[$];
  int   seen_idx2[$];
  int   checks = 0;
  int   failures = 0;
  int   mcnt = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  bit   acc = 0;
  bit   saw_stall = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected metric of every codeword, straight from the distance rules
  function automatic logic [15:0] ref_bm(input logic [5:0] rx, input logic [1:0] er, input logic hard);
    logic [15:0] r;
    int s, samp, b, d;
    r = '0;
    for (int c = 0; c < N_CW; c++) begin
      s = 0;
      for (int j = 0; j < N_OUT; j++) begin
        if (!er[j]) begin
          samp = (int'(rx) >> (j * SOFT_W)) & MAX_S;
          b = (c >> j) & 1;
          if (hard) d = ((samp >> (SOFT_W - 1)) & 1) ^ b;
          else      d = (b != 0) ? (MAX_S - samp) : samp;
          s += d;
        end
      end
      r[c*BM_W +: BM_W] = 4'(s);
    end
    return r;
  endfunction

  // One clock: check outputs against the scoreboard, record transfers
  task automatic cycle();
    exp_t e;
    cyc++;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 3 == 0);
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    #1;
    chk("in_ready", in_ready, (q.size() < 2) || out_ready);
    if (out_valid) begin
      if (q.size() == 0) chk("spurious_out", out_valid, 0);
      else begin
        e = q[0];
        chk("bm", bm_o, e.bm);
        chk("last", last_o, e.last);
        chk("idx", idx_o, e.idx);
      end
    end
    if (out_valid2 && q.size() > 0) chk("idx_w2", idx2, q[0].idx % 4);
    if (out_valid && out_ready && q.size() > 0) begin
      seen_idx.push_back(int'(idx_o));
      seen_last.push_back(int'(last_o));
      seen_idx2.push_back(int'(idx2));
      void'(q.pop_front());
    end
    acc = in_valid && in_ready;
    if (acc) begin
      e.bm   = ref_bm(rx_i, erase_i, hard_i);
      e.last = last_i;
      e.idx  = mcnt;
      q.push_back(e);
      mcnt = last_i ? 0 : (mcnt + 1) % 65536;
    end
    if (rst_n && !in_ready) saw_stall = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] rx, input logic [1:0] er, input logic hard, input logic last);
    int budget = 0;
    in_valid = 1'b1;
    rx_i = rx;
    erase_i = er;
    hard_i = hard;
    last_i = last;
    acc = 0;
    while (!acc && budget < 50) begin
      cycle();
      budget++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (q.size() > 0 && budget < 200) begin
      cycle();
      budget++;
    end
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    cycle();
    cycle();
  endtask

  task automatic clear_seen();
    seen_idx.delete();
    seen_last.delete();
    seen_idx2.delete();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bm", bm_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_idx", idx_o, 0);
    q.delete();
    mcnt = 0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
  endtask

  initial begin
    int exp_i[4];
    int exp_l[4];
    int exp_w[5];
    exp_i = '{0, 1, 2, 0};
    exp_l = '{0, 0, 1, 0};
    exp_w = '{0, 1, 2, 3, 0};

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Directed metrics with the 2-cycle latency
    rdy_mode = 0;
    send(6'b111_000, 2'b00, 1'b0, 1'b1);
    chk("lat1_valid", out_valid, 0);
    cycle();
    chk("lat2_valid", out_valid, 1);
    chk("soft_bm", bm_o, 16'h70E7);
    chk("soft_idx", idx_o, 0);
    drain();

    send(6'b111_000, 2'b00, 1'b1, 1'b1);
    cycle();
    chk("hard_valid", out_valid, 1);
    chk("hard_bm", bm_o, 16'h1021);
    drain();

    send(6'b111_000, 2'b10, 1'b0, 1'b1);
    cycle();
    chk("erase_valid", out_valid, 1);
    chk("erase_bm", bm_o, 16'h7070);
    drain();

    // Frame index restarts after last
    clear_seen();
    for (int i = 0; i < 4; i++) send(6'($urandom_range(0, 63)), 2'b00, 1'b0, 1'(exp_l[i]));
    drain();
    chk("frame_count", seen_idx.size(), 4);
    for (int i = 0; i < 4 && i < seen_idx.size(); i++) begin
      chk("frame_idx", seen_idx[i], exp_i[i]);
      chk("frame_last", seen_last[i], exp_l[i]);
    end

    // Stalling downstream, back-to-back input
    clear_seen();
    rdy_mode = 1;
    saw_stall = 0;
    for (int i = 0; i < 8; i++)
      send(6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    drain();
    chk("stall_count", seen_idx.size(), 8);
    chk("stall_ready_drop", saw_stall, 1);

    // Reset with two symbols in flight
    rdy_mode = 3;
    send(6'h15, 2'b00, 1'b0, 1'b0);
    send(6'h2A, 2'b00, 1'b0, 1'b0);
    do_reset();
    rdy_mode = 0;
    cycle();
    chk("rst_discard_valid", out_valid, 0);
    cycle();
    cycle();

    // Narrow index counter wraps
    clear_seen();
    for (int i = 0; i < 5; i++) send(6'($urandom_range(0, 63)), 2'b00, 1'b0, 1'b0);
    drain();
    chk("wrap_count", seen_idx2.size(), 5);
    for (int i = 0; i < 5 && i < seen_idx2.size(); i++) chk("wrap_idx", seen_idx2[i], exp_w[i]);
    chk("wide_after_rst_idx", seen_idx.size() > 0 ? seen_idx[0] : -1, 0);

    // Random traffic
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) cycle();
      else send(6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
